// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state codes,
// bypass-select codes and the packed bundle of stage-register enables.
// Latency: n/a (types only). Backpressure: n/a.
package hazard_ctrl_mc_pkg;

    // Controller wait states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_IWAIT = 2'd2
    } hz_state_e;

    // Operand bypass selects driven to the EX-stage operand muxes
    localparam logic [1:0] BYP_RF  = 2'b00;  // register file
    localparam logic [1:0] BYP_WB  = 2'b01;  // MEM/WB result
    localparam logic [1:0] BYP_MEM = 2'b10;  // EX/MEM result

    // Every stage-register write enable and NOP-inject, kept together so the
    // priority logic can start from one default and override fields.
    typedef struct packed {
        logic write_pc;
        logic write_ifid;
        logic write_idex;
        logic write_exmem;
        logic write_memwb;
        logic bubble_ifid;
        logic bubble_idex;
        logic bubble_exmem;
        logic bubble_memwb;
    } hz_ctrl_t;

    // Free-running pipeline: everything advances, nothing squashed
    localparam hz_ctrl_t CTRL_ADVANCE = '{
        write_pc:     1'b1,
        write_ifid:   1'b1,
        write_idex:   1'b1,
        write_exmem:  1'b1,
        write_memwb:  1'b1,
        bubble_ifid:  1'b0,
        bubble_idex:  1'b0,
        bubble_exmem: 1'b0,
        bubble_memwb: 1'b0
    };

    // Held in reset: every stage loads a NOP
    localparam hz_ctrl_t CTRL_FLUSH = '{
        write_pc:     1'b1,
        write_ifid:   1'b1,
        write_idex:   1'b1,
        write_exmem:  1'b1,
        write_memwb:  1'b1,
        bubble_ifid:  1'b1,
        bubble_idex:  1'b1,
        bubble_exmem: 1'b1,
        bubble_memwb: 1'b1
    };

endpackage

// File: rtl/hazard_bypass_unit.sv
// Operand bypass select for one EX-stage source register.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: i_rs source reg; i_exmem_*/i_memwb_* producer rd + regwrite; o_sel BYP_* code.
module hazard_bypass_unit
    import hazard_ctrl_mc_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic              i_exmem_regwrite,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic              i_memwb_regwrite,
    output logic [1:0]        o_sel
);

    logic w_hit_mem;
    logic w_hit_wb;

    // x0 is hardwired zero, so a producer targeting it never forwards
    assign w_hit_mem = i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == i_rs);
    assign w_hit_wb  = i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == i_rs);

    // The younger producer (EX/MEM) holds the newer value and wins
    always_comb begin
        o_sel = BYP_RF;
        if (w_hit_mem) begin
            o_sel = BYP_MEM;
        end else if (w_hit_wb) begin
            o_sel = BYP_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Stall/flush/bypass controller for the 5-stage RV32 pipeline with I/D caches.
// Latency: enables and bypass selects are combinational from state + inputs; state, redirect flag, watchdog registered.
// Backpressure: D-miss freezes PC..EX/MEM and bubbles MEM/WB; I-miss holds PC/IFID and bubbles ID/EX.
// Ports: i_* pipeline register fields + cache handshakes; o_write_*/o_bubble_* stage enables,
//        o_bypassA/B operand selects, o_redirect_pending, o_wdog_err, o_perf_stall/o_perf_flush.
// Optional: define HZ_PERF_CNT_EN to build the stall/flush counters; otherwise those ports read 0.
module hazard_ctrl_mc
    import hazard_ctrl_mc_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int WDOG_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [REG_AW-1:0] i_ifid_rs1,
    input  logic [REG_AW-1:0] i_ifid_rs2,
    input  logic [REG_AW-1:0] i_idex_rs1,
    input  logic [REG_AW-1:0] i_idex_rs2,
    input  logic [REG_AW-1:0] i_idex_rd,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic              i_idex_memread,
    input  logic              i_exmem_regwrite,
    input  logic              i_memwb_regwrite,
    input  logic              i_jump_id,
    input  logic              i_pcsrc,
    input  logic              i_icache_ready,
    input  logic              i_dcache_req,
    input  logic              i_dcache_ready,
    output logic              o_write_pc,
    output logic              o_write_ifid,
    output logic              o_write_idex,
    output logic              o_write_exmem,
    output logic              o_write_memwb,
    output logic              o_bubble_ifid,
    output logic              o_bubble_idex,
    output logic              o_bubble_exmem,
    output logic              o_bubble_memwb,
    output logic [1:0]        o_bypassA,
    output logic [1:0]        o_bypassB,
    output logic              o_redirect_pending,
    output logic              o_wdog_err,
    output logic [CNT_W-1:0]  o_perf_stall,
    output logic [CNT_W-1:0]  o_perf_flush
);

    localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_MAX - WDOG_W'(1);

    hz_state_e         r_state;
    logic              r_redirect_pending;
    logic [WDOG_W-1:0] r_wdog_cnt;
    logic              r_wdog_err;

    logic     w_dwait_now;
    logic     w_iwait_now;
    logic     w_run_now;
    logic     w_load_use;
    logic     w_pcsrc_act;
    logic     w_lu_act;
    logic     w_jump_act;
    logic     w_redir_release;
    logic     w_waiting;
    logic     w_wdog_hit;
    hz_ctrl_t w_ctrl;

    // Effective mode for this cycle. A new D-miss freezes in the same cycle it
    // is seen, and a DWAIT releases in the cycle dcache_ready arrives, so the
    // wait decision is taken from the current inputs rather than r_state alone.
    // DWAIT is only entered from RUN; an I-miss release lands in RUN, where a
    // pending MEM-side miss is picked up on the following cycle.
    assign w_dwait_now = ((r_state == ST_RUN)   && i_dcache_req && !i_dcache_ready) ||
                         ((r_state == ST_DWAIT) && !i_dcache_ready);
    assign w_iwait_now = !w_dwait_now && !i_icache_ready;
    assign w_run_now   = !w_dwait_now && !w_iwait_now;

    assign w_load_use = i_idex_memread && (i_idex_rd != '0) &&
                        ((i_idex_rd == i_ifid_rs1) || (i_idex_rd == i_ifid_rs2));

    // Priority: D-wait > taken branch > load-use > jump
    assign w_pcsrc_act = i_pcsrc && !w_dwait_now;
    assign w_lu_act    = w_run_now && !i_pcsrc && w_load_use;
    assign w_jump_act  = w_run_now && !i_pcsrc && !w_load_use && i_jump_id;

    // The fetch returning as IWAIT ends belongs to the old path; squash it
    assign w_redir_release = (r_state == ST_IWAIT) && i_icache_ready && r_redirect_pending;

    always_comb begin
        w_ctrl = CTRL_ADVANCE;
        if (i_reset) begin
            w_ctrl = CTRL_FLUSH;
        end else if (w_dwait_now) begin
            // Hold everything upstream of the stalled MEM access; WB drains a NOP
            w_ctrl.write_pc     = 1'b0;
            w_ctrl.write_ifid   = 1'b0;
            w_ctrl.write_idex   = 1'b0;
            w_ctrl.write_exmem  = 1'b0;
            w_ctrl.bubble_memwb = 1'b1;
        end else begin
            if (w_iwait_now) begin
                w_ctrl.write_pc    = 1'b0;
                w_ctrl.write_ifid  = 1'b0;
                w_ctrl.bubble_idex = 1'b1;
            end
            if (w_pcsrc_act) begin
                // Branch target is loaded even while the I-side is waiting
                w_ctrl.write_pc     = 1'b1;
                w_ctrl.bubble_ifid  = 1'b1;
                w_ctrl.bubble_idex  = 1'b1;
                w_ctrl.bubble_exmem = 1'b1;
            end else if (w_lu_act) begin
                w_ctrl.write_pc    = 1'b0;
                w_ctrl.write_ifid  = 1'b0;
                w_ctrl.bubble_idex = 1'b1;
            end else if (w_jump_act) begin
                w_ctrl.bubble_ifid = 1'b1;
            end
            if (w_redir_release) begin
                w_ctrl.bubble_ifid = 1'b1;
            end
        end
    end

    assign o_write_pc     = w_ctrl.write_pc;
    assign o_write_ifid   = w_ctrl.write_ifid;
    assign o_write_idex   = w_ctrl.write_idex;
    assign o_write_exmem  = w_ctrl.write_exmem;
    assign o_write_memwb  = w_ctrl.write_memwb;
    assign o_bubble_ifid  = w_ctrl.bubble_ifid;
    assign o_bubble_idex  = w_ctrl.bubble_idex;
    assign o_bubble_exmem = w_ctrl.bubble_exmem;
    assign o_bubble_memwb = w_ctrl.bubble_memwb;

    // Wait FSM and wrong-path fetch flag
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state            <= ST_RUN;
            r_redirect_pending <= 1'b0;
        end else begin
            if (w_dwait_now) begin
                r_state <= ST_DWAIT;
            end else if (w_iwait_now) begin
                r_state <= ST_IWAIT;
            end else begin
                r_state <= ST_RUN;
            end

            if (w_iwait_now && i_pcsrc) begin
                r_redirect_pending <= 1'b1;
            end else if (w_run_now) begin
                r_redirect_pending <= 1'b0;
            end
        end
    end

    assign o_redirect_pending = r_redirect_pending;

    // Miss watchdog: r_wdog_cnt holds the number of consecutive wait cycles
    // before this one, so the timeout is flagged in the cycle that completes
    // the run of 2**WDOG_W-1 waits, then held by the sticky register.
    assign w_waiting  = !i_reset && (w_dwait_now || w_iwait_now);
    assign w_wdog_hit = w_waiting && (r_wdog_cnt == WDOG_LAST);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (!w_waiting) begin
                r_wdog_cnt <= '0;
            end else if (r_wdog_cnt != WDOG_MAX) begin
                r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
            end
            if (w_wdog_hit) begin
                r_wdog_err <= 1'b1;
            end
        end
    end

    assign o_wdog_err = r_wdog_err || w_wdog_hit;

`ifdef HZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_stall;
    logic [CNT_W-1:0] r_perf_flush;
    logic             w_stall_evt;
    logic             w_flush_evt;

    assign w_stall_evt = !i_reset && !w_ctrl.write_pc;
    assign w_flush_evt = !i_reset && (w_pcsrc_act || w_jump_act);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_stall_evt && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + CNT_W'(1);
            end
            if (w_flush_evt && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + CNT_W'(1);
            end
        end
    end

    assign o_perf_stall = r_perf_stall;
    assign o_perf_flush = r_perf_flush;
`else
    assign o_perf_stall = '0;
    assign o_perf_flush = '0;
`endif

    hazard_bypass_unit #(.REG_AW(REG_AW)) u_byp_a (
        .i_rs             (i_idex_rs1),
        .i_exmem_rd       (i_exmem_rd),
        .i_exmem_regwrite (i_exmem_regwrite),
        .i_memwb_rd       (i_memwb_rd),
        .i_memwb_regwrite (i_memwb_regwrite),
        .o_sel            (o_bypassA)
    );

    hazard_bypass_unit #(.REG_AW(REG_AW)) u_byp_b (
        .i_rs             (i_idex_rs2),
        .i_exmem_rd       (i_exmem_rd),
        .i_exmem_regwrite (i_exmem_regwrite),
        .i_memwb_rd       (i_memwb_rd),
        .i_memwb_regwrite (i_memwb_regwrite),
        .o_sel            (o_bypassB)
    );

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc (built with WDOG_W=3).
// Vectors are driven 1 time unit after the rising edge; expected outputs go into a queue
// and are popped and compared on the falling edge of the same cycle.
module tb_hazard_ctrl_mc;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    // {write pc,ifid,idex,exmem,memwb, bubble ifid,idex,exmem,memwb}
    localparam logic [8:0] C_NORM = 9'b11111_0000;
    localparam logic [8:0] C_RST  = 9'b11111_1111;
    localparam logic [8:0] C_LU   = 9'b00111_0100;
    localparam logic [8:0] C_IW   = 9'b00111_0100;
    localparam logic [8:0] C_DW   = 9'b00001_0001;
    localparam logic [8:0] C_IWBR = 9'b10111_1110;
    localparam logic [8:0] C_BR   = 9'b11111_1110;
    localparam logic [8:0] C_SQ1  = 9'b11111_1000;

    typedef struct packed {
        logic       rst;
        logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
        logic       memread, exmem_rw, memwb_rw, jump, pcsrc, iready, dreq, dready;
    } vin_t;

    typedef struct packed {
        logic [8:0] ctrl;
        logic [1:0] ba;
        logic [1:0] bb;
        logic       redir;
        logic       wdog;
        logic       perf0;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [REG_AW-1:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
    logic              idex_memread, exmem_regwrite, memwb_regwrite, jump_id, pcsrc;
    logic              icache_ready, dcache_req, dcache_ready;
    logic              write_pc, write_ifid, write_idex, write_exmem, write_memwb;
    logic              bubble_ifid, bubble_idex, bubble_exmem, bubble_memwb;
    logic [1:0]        bypassA, bypassB;
    logic              redirect_pending, wdog_err;
    logic [CNT_W-1:0]  perf_stall, perf_flush;

    hazard_ctrl_mc #(.REG_AW(REG_AW), .WDOG_W(3), .CNT_W(CNT_W)) dut (
        .i_clock            (clk),
        .i_reset            (reset),
        .i_ifid_rs1         (ifid_rs1),
        .i_ifid_rs2         (ifid_rs2),
        .i_idex_rs1         (idex_rs1),
        .i_idex_rs2         (idex_rs2),
        .i_idex_rd          (idex_rd),
        .i_exmem_rd         (exmem_rd),
        .i_memwb_rd         (memwb_rd),
        .i_idex_memread     (idex_memread),
        .i_exmem_regwrite   (exmem_regwrite),
        .i_memwb_regwrite   (memwb_regwrite),
        .i_jump_id          (jump_id),
        .i_pcsrc            (pcsrc),
        .i_icache_ready     (icache_ready),
        .i_dcache_req       (dcache_req),
        .i_dcache_ready     (dcache_ready),
        .o_write_pc         (write_pc),
        .o_write_ifid       (write_ifid),
        .o_write_idex       (write_idex),
        .o_write_exmem      (write_exmem),
        .o_write_memwb      (write_memwb),
        .o_bubble_ifid      (bubble_ifid),
        .o_bubble_idex      (bubble_idex),
        .o_bubble_exmem     (bubble_exmem),
        .o_bubble_memwb     (bubble_memwb),
        .o_bypassA          (bypassA),
        .o_bypassB          (bypassB),
        .o_redirect_pending (redirect_pending),
        .o_wdog_err         (wdog_err),
        .o_perf_stall       (perf_stall),
        .o_perf_flush       (perf_flush)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    exp_t  q_exp[$];
    string q_tag[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic vin_t idle();
        vin_t v;
        v        = '0;
        v.iready = 1'b1;
        return v;
    endfunction

    task automatic apply(input vin_t v);
        reset          = v.rst;
        ifid_rs1       = v.ifid_rs1;
        ifid_rs2       = v.ifid_rs2;
        idex_rs1       = v.idex_rs1;
        idex_rs2       = v.idex_rs2;
        idex_rd        = v.idex_rd;
        exmem_rd       = v.exmem_rd;
        memwb_rd       = v.memwb_rd;
        idex_memread   = v.memread;
        exmem_regwrite = v.exmem_rw;
        memwb_regwrite = v.memwb_rw;
        jump_id        = v.jump;
        pcsrc          = v.pcsrc;
        icache_ready   = v.iready;
        dcache_req     = v.dreq;
        dcache_ready   = v.dready;
    endtask

    // One pipeline cycle: drive the vector and queue what the spec says the
    // controller must show during this cycle.
    task automatic step(input vin_t v, input logic [8:0] ctrl, input logic [1:0] ba,
                        input logic [1:0] bb, input logic redir, input logic wdog,
                        input logic perf0, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        apply(v);
        e.ctrl  = ctrl;
        e.ba    = ba;
        e.bb    = bb;
        e.redir = redir;
        e.wdog  = wdog;
        e.perf0 = perf0;
        q_exp.push_back(e);
        q_tag.push_back(tag);
    endtask

    exp_t  mon_e;
    string mon_t;
    always @(negedge clk) begin
        if (q_exp.size() != 0) begin
            mon_e = q_exp.pop_front();
            mon_t = q_tag.pop_front();
            chk({mon_t, ".ctrl"}, 32'({write_pc, write_ifid, write_idex, write_exmem, write_memwb,
                                       bubble_ifid, bubble_idex, bubble_exmem, bubble_memwb}),
                32'(mon_e.ctrl));
            chk({mon_t, ".bypA"},  32'(bypassA), 32'(mon_e.ba));
            chk({mon_t, ".bypB"},  32'(bypassB), 32'(mon_e.bb));
            chk({mon_t, ".redir"}, 32'(redirect_pending), 32'(mon_e.redir));
            chk({mon_t, ".wdog"},  32'(wdog_err), 32'(mon_e.wdog));
            if (mon_e.perf0) begin
                chk({mon_t, ".pstall"}, perf_stall, 32'd0);
                chk({mon_t, ".pflush"}, perf_flush, 32'd0);
            end
        end
    end

    initial begin
        vin_t v;
        v = idle();
        v.rst = 1'b1;
        apply(v);
        repeat (2) @(posedge clk);

        // Reset: full flush regardless of cache handshakes
        v = idle(); v.rst = 1'b1; v.dreq = 1'b1; v.iready = 1'b0;
        step(v, C_RST, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "rst");
        v = idle();
        step(v, C_NORM, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, "idle");

        // 1: lw x5 in EX, add x6,x5,x1 in ID
        v = idle(); v.memread = 1'b1; v.idex_rd = 5'd5; v.ifid_rs1 = 5'd5; v.ifid_rs2 = 5'd1;
        step(v, C_LU, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "lu.stall");
        v = idle(); v.exmem_rd = 5'd5; v.exmem_rw = 1'b1; v.ifid_rs1 = 5'd5; v.ifid_rs2 = 5'd1;
        step(v, C_NORM, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "lu.bubble");
        v = idle(); v.memwb_rd = 5'd5; v.memwb_rw = 1'b1; v.idex_rs1 = 5'd5; v.idex_rs2 = 5'd1;
        step(v, C_NORM, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, "lu.fwd");
        v = idle(); v.memread = 1'b1; v.idex_rd = 5'd0; v.ifid_rs1 = 5'd0;
        step(v, C_NORM, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "lu.x0");
        v = idle(); v.memread = 1'b1; v.idex_rd = 5'd9; v.ifid_rs2 = 5'd9;
        step(v, C_LU, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "lu.rs2");

        // Control-flow priority in RUN
        v = idle(); v.pcsrc = 1'b1;
        step(v, C_BR, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "br.run");
        v = idle(); v.pcsrc = 1'b1; v.memread = 1'b1; v.idex_rd = 5'd4; v.ifid_rs1 = 5'd4;
        step(v, C_BR, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "br.over.lu");
        v = idle(); v.jump = 1'b1;
        step(v, C_SQ1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "jmp");
        v = idle(); v.jump = 1'b1; v.memread = 1'b1; v.idex_rd = 5'd4; v.ifid_rs2 = 5'd4;
        step(v, C_LU, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "lu.over.jmp");

        // 2: three-cycle D-miss, pcsrc ignored while frozen, release on ready
        v = idle(); v.dreq = 1'b1;
        step(v, C_DW, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "dw.c1");
        v.pcsrc = 1'b1;
        step(v, C_DW, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "dw.c2");
        v.pcsrc = 1'b0;
        step(v, C_DW, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "dw.c3");
        v.dready = 1'b1;
        step(v, C_NORM, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "dw.rel");
        v = idle();
        step(v, C_NORM, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "dw.after");

        // D-miss release straight into an I-miss
        v = idle(); v.dreq = 1'b1;
        step(v, C_DW, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "dwi.c1");
        v.dready = 1'b1; v.iready = 1'b0;
        step(v, C_IW, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "dwi.iw");
        v = idle();
        step(v, C_NORM, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "dwi.run");

        // 3: branch taken while waiting on fetch
        v = idle(); v.iready = 1'b0;
        step(v, C_IW, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "iw.c1");
        v.pcsrc = 1'b1;
        step(v, C_IWBR, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "iw.br");
        v.pcsrc = 1'b0;
        step(v, C_IW, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, "iw.pend");
        v.iready = 1'b1;
        step(v, C_SQ1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, "iw.rel");
        v = idle();
        step(v, C_NORM, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "iw.clr");

        // 4: forwarding priority and x0
        v = idle(); v.exmem_rd = 5'd7; v.memwb_rd = 5'd7; v.exmem_rw = 1'b1; v.memwb_rw = 1'b1;
        v.idex_rs1 = 5'd3; v.idex_rs2 = 5'd7;
        step(v, C_NORM, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, "byp.mem");
        v.exmem_rd = 5'd0; v.memwb_rd = 5'd0; v.idex_rs2 = 5'd0;
        step(v, C_NORM, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "byp.x0");
        v.exmem_rd = 5'd7; v.memwb_rd = 5'd7; v.exmem_rw = 1'b0; v.idex_rs1 = 5'd7; v.idex_rs2 = 5'd7;
        step(v, C_NORM, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, "byp.wb");
        v = idle(); v.dreq = 1'b1; v.exmem_rd = 5'd12; v.exmem_rw = 1'b1; v.idex_rs1 = 5'd12;
        step(v, C_DW, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, "byp.dw");
        v.dready = 1'b1;
        step(v, C_NORM, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, "byp.rel");
        v = idle();
        step(v, C_NORM, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "pre.wd");

        // 5: seven-cycle D-miss trips the 3-bit watchdog, error is sticky
        v = idle(); v.dreq = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(v, C_DW, 2'b00, 2'b00, 1'b0, (i >= 7), 1'b0, $sformatf("wd.c%0d", i));
        end
        v.dready = 1'b1;
        step(v, C_NORM, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, "wd.rel");
        v = idle();
        step(v, C_NORM, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, "wd.sticky");

        // 6: reset in the middle of a D-miss
        v = idle(); v.dreq = 1'b1;
        step(v, C_DW, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, "rdw.c1");
        v.rst = 1'b1;
        step(v, C_RST, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, "rdw.rst");
        v = idle();
        step(v, C_NORM, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, "rdw.run");

        // Reset while a wrong-path fetch is outstanding drops the redirect
        v = idle(); v.iready = 1'b0; v.pcsrc = 1'b1;
        step(v, C_IWBR, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "riw.br");
        v.pcsrc = 1'b0; v.rst = 1'b1;
        step(v, C_RST, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, "riw.rst");
        v = idle();
        step(v, C_NORM, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, "riw.run");

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
